// File: rtl/alu_seq_ctrl_if.sv
// Handshake and operand/result bundle between the decoder side and the ALU sequencer.
// The sequencer takes the slave modport.
interface alu_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic                 op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic                 dz;
  logic                 s1;
  logic                 s0;
  logic                 cin;

  modport master (
    output start, op, a, b,
    input  busy, done, result, dz, s1, s0, cin
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, dz, s1, s0, cin
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle shift-add multiply / restoring divide sequencer, one ALU pass per clock.
// The registered B-select and carry-in drive both the external ALU and the internal adder.
module alu_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  alu_seq_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 dz_q, dz_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 s1_q, s1_d;
  logic                 s0_q, s0_d;
  logic                 cin_q, cin_d;

  logic [WIDTH:0]       alu_a_s;
  logic [WIDTH:0]       bsel_s;
  logic [WIDTH+1:0]     sum_s;
  logic                 qbit_s;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    q_d      = q_q;
    count_d  = count_q;
    result_d = result_q;
    dz_d     = dz_q;
    qbit_s   = 1'b0;

    // Divide shifts the next dividend bit into the partial remainder before the subtract.
    if (op_q) begin
      alu_a_s = {acc_q, q_q[WIDTH-1]};
    end else begin
      alu_a_s = {1'b0, acc_q};
    end

    case ({s1_q, s0_q})
      2'b00:   bsel_s = {(WIDTH+1){1'b0}};
      2'b01:   bsel_s = {1'b0, b_q};
      2'b10:   bsel_s = {1'b1, ~b_q};
      default: bsel_s = {(WIDTH+1){1'b1}};
    endcase

    sum_s = {1'b0, alu_a_s} + {1'b0, bsel_s} + {{(WIDTH+1){1'b0}}, cin_q};

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_ITER;
          op_d    = bus.op;
          a_d     = bus.a;
          b_d     = bus.b;
          acc_d   = {WIDTH{1'b0}};
          q_d     = bus.a;
          count_d = {CW{1'b0}};
          dz_d    = bus.op & (bus.b == {WIDTH{1'b0}});
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ITER: begin
        if (op_q) begin
          // Carry out of the (WIDTH+1)-bit subtract means no borrow: r' >= b.
          if (sum_s[WIDTH+1]) begin
            acc_d  = sum_s[WIDTH-1:0];
            qbit_s = 1'b1;
          end else begin
            acc_d  = alu_a_s[WIDTH-1:0];
            qbit_s = 1'b0;
          end
          q_d = {q_q[WIDTH-2:0], qbit_s};
        end else begin
          acc_d = sum_s[WIDTH:1];
          q_d   = {sum_s[0], q_q[WIDTH-1:1]};
        end
        count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = ST_DONE;
          if (op_q && dz_q) begin
            result_d = {a_q, {WIDTH{1'b1}}};
          end else begin
            result_d = {acc_d, q_d};
          end
        end else begin
          state_d = ST_ITER;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_ITER);
    done_d = (state_d == ST_DONE);
    if (state_d == ST_ITER) begin
      s1_d  = op_d;
      s0_d  = ~op_d & q_d[0];
      cin_d = op_d;
    end else begin
      s1_d  = 1'b0;
      s0_d  = 1'b0;
      cin_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= 1'b0;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      q_q      <= {WIDTH{1'b0}};
      count_q  <= {CW{1'b0}};
      result_q <= {(2*WIDTH){1'b0}};
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      s1_q     <= 1'b0;
      s0_q     <= 1'b0;
      cin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      count_q  <= count_d;
      result_q <= result_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      s1_q     <= s1_d;
      s0_q     <= s0_d;
      cin_q    <= cin_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.dz     = dz_q;
  assign bus.s1     = s1_q;
  assign bus.s0     = s0_q;
  assign bus.cin    = cin_q;

endmodule
